// File: rtl/button_pulser.sv
// Four-channel button front end: 2-flop synchronizer, debouncer and repeat FSM per
// button, followed by a fixed-priority (L > R > U > D) single-pulse arbiter.
module button_pulser #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 15000000,
  parameter int CNT_W           = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnL_raw,
  input  logic       btnR_raw,
  input  logic       btnU_raw,
  input  logic       btnD_raw,
  output logic       btnL,
  output logic       btnR,
  output logic       btnU,
  output logic       btnD,
  output logic [3:0] held
);

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_DELAY    = 2'd1,
    ST_REPEAT   = 2'd2
  } state_e;

  // A count "reaches" N on the edge that would take it from N-1 to N.
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [3:0]       raw_s;
  logic [3:0]       sync1_q;
  logic [3:0]       sync2_q;
  logic [3:0]       stable_q;
  logic [3:0]       stable_d;
  logic [CNT_W-1:0] db_cnt_q  [4];
  logic [CNT_W-1:0] db_cnt_d  [4];
  state_e           state_q   [4];
  state_e           state_d   [4];
  logic [CNT_W-1:0] rep_cnt_q [4];
  logic [CNT_W-1:0] rep_cnt_d [4];
  logic [3:0]       req_s;
  logic [3:0]       grant_s;
  logic [3:0]       pulse_q;

  assign raw_s = {btnD_raw, btnU_raw, btnR_raw, btnL_raw};

  // Synchronizer, debounce, FSM and output pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= 4'b0000;
      sync2_q  <= 4'b0000;
      stable_q <= 4'b0000;
      pulse_q  <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i]  <= CNT_ZERO;
        state_q[i]   <= ST_RELEASED;
        rep_cnt_q[i] <= CNT_ZERO;
      end
    end else begin
      sync1_q  <= raw_s;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      pulse_q  <= grant_s;
      for (int i = 0; i < 4; i++) begin
        db_cnt_q[i]  <= db_cnt_d[i];
        state_q[i]   <= state_d[i];
        rep_cnt_q[i] <= rep_cnt_d[i];
      end
    end
  end

  // Debouncer: any cycle of agreement restarts the count.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < 4; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (sync2_q[i] == stable_q[i]) begin
        db_cnt_d[i] = CNT_ZERO;
      end else if (db_cnt_q[i] == DB_LAST) begin
        stable_d[i] = ~stable_q[i];
        db_cnt_d[i] = CNT_ZERO;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + CNT_ONE;
      end
    end
  end

  // Repeat FSM: press is taken from the registered level so the pulse trails held
  // by one cycle; release uses the next level so no pulse can land on the fall edge.
  always_comb begin
    req_s = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      state_d[i]   = state_q[i];
      rep_cnt_d[i] = rep_cnt_q[i];
      case (state_q[i])
        ST_RELEASED: begin
          rep_cnt_d[i] = CNT_ZERO;
          if (stable_q[i] && stable_d[i]) begin
            req_s[i]   = 1'b1;
            state_d[i] = ST_DELAY;
          end else begin
            state_d[i] = ST_RELEASED;
          end
        end
        ST_DELAY: begin
          if (!stable_d[i]) begin
            state_d[i]   = ST_RELEASED;
            rep_cnt_d[i] = CNT_ZERO;
          end else if (rep_cnt_q[i] == RD_LAST) begin
            req_s[i]     = 1'b1;
            state_d[i]   = ST_REPEAT;
            rep_cnt_d[i] = CNT_ZERO;
          end else begin
            rep_cnt_d[i] = rep_cnt_q[i] + CNT_ONE;
          end
        end
        ST_REPEAT: begin
          if (!stable_d[i]) begin
            state_d[i]   = ST_RELEASED;
            rep_cnt_d[i] = CNT_ZERO;
          end else if (rep_cnt_q[i] == RP_LAST) begin
            req_s[i]     = 1'b1;
            rep_cnt_d[i] = CNT_ZERO;
          end else begin
            rep_cnt_d[i] = rep_cnt_q[i] + CNT_ONE;
          end
        end
        default: begin
          state_d[i]   = ST_RELEASED;
          rep_cnt_d[i] = CNT_ZERO;
        end
      endcase
    end
  end

  // Losing requests are dropped; their FSMs have already advanced above.
  always_comb begin
    grant_s = 4'b0000;
    if (req_s[0]) begin
      grant_s = 4'b0001;
    end else if (req_s[1]) begin
      grant_s = 4'b0010;
    end else if (req_s[2]) begin
      grant_s = 4'b0100;
    end else if (req_s[3]) begin
      grant_s = 4'b1000;
    end else begin
      grant_s = 4'b0000;
    end
  end

  assign btnL = pulse_q[0];
  assign btnR = pulse_q[1];
  assign btnU = pulse_q[2];
  assign btnD = pulse_q[3];
  assign held = stable_q;

endmodule

// File: tb/tb_button_pulser.sv
// Directed bench for button_pulser with DEBOUNCE_CYCLES=4, REPEAT_DELAY=20,
// REPEAT_PERIOD=8; pulse and held edges are logged by edge number and compared.
module tb_button_pulser;

  logic       clk;
  logic       rst;
  logic       btnL_raw, btnR_raw, btnU_raw, btnD_raw;
  logic       btnL, btnR, btnU, btnD;
  logic [3:0] held;

  int         cyc;
  int         checks;
  int         failures;
  int         multi_cnt;
  int         q_l[$];
  int         q_r[$];
  int         q_u[$];
  int         q_d[$];
  int         rise_e [4];
  int         fall_e [4];
  logic [3:0] held_prev;
  int         exp_q[$];

  button_pulser #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8),
    .CNT_W          (27)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btnL_raw(btnL_raw),
    .btnR_raw(btnR_raw),
    .btnU_raw(btnU_raw),
    .btnD_raw(btnD_raw),
    .btnL    (btnL),
    .btnR    (btnR),
    .btnU    (btnU),
    .btnD    (btnD),
    .held    (held)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter: after posedge n settles, cyc == n.
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor on the falling edge: log pulses and held transitions by edge number.
  always @(negedge clk) begin
    if (btnL) q_l.push_back(cyc);
    if (btnR) q_r.push_back(cyc);
    if (btnU) q_u.push_back(cyc);
    if (btnD) q_d.push_back(cyc);
    if ((int'(btnL) + int'(btnR) + int'(btnU) + int'(btnD)) > 1) multi_cnt <= multi_cnt + 1;
    for (int i = 0; i < 4; i++) begin
      if (held[i] && !held_prev[i]) rise_e[i] <= cyc;
      if (!held[i] && held_prev[i]) fall_e[i] <= cyc;
    end
    held_prev <= held;
  end

  task automatic check_val(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_list(input string tag, input int obs[$], input int exp[$]);
    check_val({tag, "_count"}, obs.size(), exp.size());
    for (int i = 0; i < obs.size() && i < exp.size(); i++) begin
      check_val($sformatf("%s_edge%0d", tag, i), obs[i], exp[i]);
    end
  endtask

  task automatic goto_edge(input int k);
    while (cyc < k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_logs();
    q_l.delete();
    q_r.delete();
    q_u.delete();
    q_d.delete();
  endtask

  int hi_tab [8] = '{1, 2, 3, 1, 3, 2, 3, 3};
  int lo_tab [8] = '{1, 1, 2, 2, 1, 3, 1, 2};

  initial begin
    cyc       = 0;
    checks    = 0;
    failures  = 0;
    multi_cnt = 0;
    held_prev = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      rise_e[i] = -1;
      fall_e[i] = -1;
    end
    rst      = 1'b0;
    btnL_raw = 1'b0;
    btnR_raw = 1'b0;
    btnU_raw = 1'b0;
    btnD_raw = 1'b0;
    #2 rst = 1'b1;

    // Reset state
    goto_edge(3);
    check_val("reset_pulses", {btnD, btnU, btnR, btnL}, 0);
    check_val("reset_held", held, 0);
    rst = 1'b0;

    // Clean press/release on R: 12 high samples from edge 11
    goto_edge(10);
    clear_logs();
    btnR_raw = 1'b1;
    goto_edge(22);
    btnR_raw = 1'b0;
    goto_edge(40);
    exp_q = '{17};
    check_list("clean_R", q_r, exp_q);
    check_val("clean_L_count", q_l.size(), 0);
    check_val("clean_U_count", q_u.size(), 0);
    check_val("clean_D_count", q_d.size(), 0);
    check_val("clean_held1_rise", rise_e[1], 16);
    check_val("clean_held1_fall", fall_e[1], 28);

    // Bounce rejection on U: glitch table spans edges 51..81, stable from 82
    goto_edge(50);
    clear_logs();
    for (int p = 0; p < 8; p++) begin
      btnU_raw = 1'b1;
      repeat (hi_tab[p]) begin @(posedge clk); #1; end
      btnU_raw = 1'b0;
      repeat (lo_tab[p]) begin @(posedge clk); #1; end
    end
    check_val("bounce_table_end", cyc, 81);
    btnU_raw = 1'b1;
    goto_edge(95);
    btnU_raw = 1'b0;
    goto_edge(110);
    exp_q = '{88};
    check_list("bounce_U", q_u, exp_q);
    check_val("bounce_held2_rise", rise_e[2], 87);
    check_val("bounce_held2_fall", fall_e[2], 101);

    // Auto-repeat on D
    goto_edge(120);
    clear_logs();
    btnD_raw = 1'b1;
    goto_edge(186);
    btnD_raw = 1'b0;
    goto_edge(205);
    exp_q = '{127, 147, 155, 163, 171, 179, 187};
    check_list("repeat_D", q_d, exp_q);
    check_val("repeat_held3_rise", rise_e[3], 126);
    check_val("repeat_held3_fall", fall_e[3], 192);
    check_val("repeat_L_count", q_l.size(), 0);

    // Priority collision: L and R together
    goto_edge(210);
    clear_logs();
    btnL_raw = 1'b1;
    btnR_raw = 1'b1;
    goto_edge(260);
    btnL_raw = 1'b0;
    btnR_raw = 1'b0;
    goto_edge(280);
    exp_q = '{217, 237, 245, 253, 261};
    check_list("prio_L", q_l, exp_q);
    check_val("prio_R_count", q_r.size(), 0);
    check_val("prio_held0_rise", rise_e[0], 216);
    check_val("prio_held1_rise", rise_e[1], 216);
    check_val("prio_held0_fall", fall_e[0], 266);

    // Reset mid-hold while L is in REPEAT and its pulse is high
    goto_edge(290);
    clear_logs();
    btnL_raw = 1'b1;
    goto_edge(325);
    check_val("prerst_btnL", btnL, 1);
    #1 rst = 1'b1;
    #1;
    check_val("rst_btnL_immediate", btnL, 0);
    check_val("rst_held_immediate", held, 0);
    goto_edge(327);
    #1 rst = 1'b0;
    goto_edge(340);
    btnL_raw = 1'b0;
    goto_edge(355);
    exp_q = '{297, 317, 334};
    check_list("rsthold_L", q_l, exp_q);
    check_val("rsthold_held0_rise", rise_e[0], 333);
    check_val("rsthold_held0_fall", fall_e[0], 346);

    // Short-tap boundary: 3-sample tap ignored, 4-sample tap gives one pulse
    goto_edge(360);
    clear_logs();
    btnL_raw = 1'b1;
    goto_edge(363);
    btnL_raw = 1'b0;
    goto_edge(380);
    check_val("tap3_L_count", q_l.size(), 0);
    btnL_raw = 1'b1;
    goto_edge(384);
    btnL_raw = 1'b0;
    goto_edge(400);
    exp_q = '{387};
    check_list("tap4_L", q_l, exp_q);
    check_val("tap4_held0_rise", rise_e[0], 386);
    check_val("tap4_held0_fall", fall_e[0], 390);

    check_val("onehot_violations", multi_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
